// File: rtl/led_matrix_pkg.sv
// Shared types and constants for the HUB75 LED-matrix scanner.
// Pin positions within pnl_rgb and the BCM plane-to-bit mapping.
package led_matrix_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_T,
        ST_FETCH_B,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LATCH,
        ST_DISPLAY
    } scan_state_t;

    localparam int PIN_R1 = 5;
    localparam int PIN_G1 = 4;
    localparam int PIN_B1 = 3;
    localparam int PIN_R2 = 2;
    localparam int PIN_G2 = 1;
    localparam int PIN_B2 = 0;

    // Planes use the top color_bits of each 8-bit channel, plane 0 being the least significant.
    function automatic int unsigned plane_bit(input int unsigned color_bits, input int unsigned plane);
        return 8 - color_bits + plane;
    endfunction

endpackage

// File: rtl/led_matrix_bcm_timer.sv
// Loadable down-counter that times one BCM display interval.
// done is high while the count sits at zero (terminal count).
module led_matrix_bcm_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/led_matrix_scanner.sv
// HUB75 panel scanner: fetches top/bottom pixel pairs from the frame buffer,
// shifts one BCM plane per row, latches, then displays for BASE_TICKS<<plane cycles.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | panel blanked, waiting for enable; row/plane retained
// ST_FETCH_T  | read strobe for the top-half pixel of the current column
// ST_FETCH_B  | capture top word, read strobe for the bottom-half pixel
// ST_SHIFT_LO | bottom word arrives, plane bits on pnl_rgb, pnl_clk low
// ST_SHIFT_HI | pnl_clk high, pnl_rgb held; advance column or go latch
// ST_LATCH    | blanked, latch pulse, row select updated
// ST_DISPLAY  | pnl_oe_n low until the BCM timer expires
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int HEIGHT     = 32,
    parameter int COLOR_BITS = 4,
    parameter int FB_BASE    = 0,
    parameter int BASE_TICKS = 32,
    parameter int ADDR_W     = 16,
    parameter int ROW_W      = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    input  logic [31:0]       mem_readdata,
    output logic [5:0]        pnl_rgb,
    output logic [ROW_W-1:0]  pnl_row,
    output logic              pnl_clk,
    output logic              pnl_lat,
    output logic              pnl_oe_n,
    output logic              frame_done
);

    localparam int COL_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PLANE_W    = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
    localparam int CNT_W      = $clog2(BASE_TICKS) + COLOR_BITS;
    localparam int SCAN_LINES = HEIGHT / 2;

    scan_state_t        state;
    logic [ROW_W-1:0]   row;
    logic [ROW_W-1:0]   row_next;
    logic [PLANE_W-1:0] plane;
    logic [COL_W-1:0]   col;
    logic [23:0]        top_word;
    logic [5:0]         rgb_q;
    logic [5:0]         rgb_live;
    logic [2:0]         bit_sel;
    logic [2:0]         top_bits;
    logic [2:0]         bot_bits;
    logic               last_col;
    logic               last_plane;
    logic               last_row;
    logic               timer_done;
    logic [CNT_W-1:0]   timer_load_value;
    logic               unused_high_byte;

    // Address math is done in 32 bits and truncated, so it wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] pix_addr(input int unsigned y, input int unsigned x);
        return ADDR_W'(FB_BASE + y * WIDTH + x);
    endfunction

    function automatic logic [2:0] pick(input logic [23:0] w, input logic [2:0] b);
        logic [7:0] m;
        m = 8'd1 << b;
        return {|(w[23:16] & m), |(w[15:8] & m), |(w[7:0] & m)};
    endfunction

    assign last_col   = (col == COL_W'(WIDTH - 1));
    assign last_plane = (plane == PLANE_W'(COLOR_BITS - 1));
    assign last_row   = (row == ROW_W'(SCAN_LINES - 1));
    assign row_next   = !last_plane ? row : (last_row ? '0 : row + 1'b1);
    assign unused_high_byte = ^mem_readdata[31:24];

    always_comb begin
        bit_sel  = 3'(plane_bit(COLOR_BITS, 32'(plane)));
        top_bits = pick(top_word, bit_sel);
        bot_bits = pick(mem_readdata[23:0], bit_sel);
        rgb_live = '0;
        rgb_live[PIN_R1] = top_bits[2];
        rgb_live[PIN_G1] = top_bits[1];
        rgb_live[PIN_B1] = top_bits[0];
        rgb_live[PIN_R2] = bot_bits[2];
        rgb_live[PIN_G2] = bot_bits[1];
        rgb_live[PIN_B2] = bot_bits[0];
    end

    // The bottom word only arrives during SHIFT_LO, so that cycle shows it live; SHIFT_HI holds the copy.
    assign pnl_rgb = (state == ST_SHIFT_LO) ? rgb_live : rgb_q;

    assign timer_load_value = CNT_W'((BASE_TICKS << plane) - 1);

    led_matrix_bcm_timer #(.CNT_W(CNT_W)) u_bcm_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (state == ST_LATCH),
        .load_value (timer_load_value),
        .done       (timer_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            row         <= '0;
            plane       <= '0;
            col         <= '0;
            top_word    <= '0;
            rgb_q       <= '0;
            mem_address <= '0;
            mem_read    <= 1'b0;
            pnl_row     <= '0;
            pnl_clk     <= 1'b0;
            pnl_lat     <= 1'b0;
            pnl_oe_n    <= 1'b1;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    pnl_oe_n <= 1'b1;
                    if (enable) begin
                        state       <= ST_FETCH_T;
                        mem_read    <= 1'b1;
                        mem_address <= pix_addr(32'(row), 32'(col));
                    end
                end
                ST_FETCH_T: begin
                    state       <= ST_FETCH_B;
                    mem_address <= pix_addr(32'(row) + SCAN_LINES, 32'(col));
                end
                ST_FETCH_B: begin
                    top_word <= mem_readdata[23:0];
                    mem_read <= 1'b0;
                    state    <= ST_SHIFT_LO;
                end
                ST_SHIFT_LO: begin
                    rgb_q   <= rgb_live;
                    pnl_clk <= 1'b1;
                    state   <= ST_SHIFT_HI;
                end
                ST_SHIFT_HI: begin
                    pnl_clk <= 1'b0;
                    if (last_col) begin
                        col     <= '0;
                        pnl_lat <= 1'b1;
                        pnl_row <= row;
                        state   <= ST_LATCH;
                    end else begin
                        col         <= col + 1'b1;
                        mem_read    <= 1'b1;
                        mem_address <= pix_addr(32'(row), 32'(col) + 1);
                        state       <= ST_FETCH_T;
                    end
                end
                ST_LATCH: begin
                    pnl_lat  <= 1'b0;
                    pnl_oe_n <= 1'b0;
                    state    <= ST_DISPLAY;
                end
                ST_DISPLAY: begin
                    if (timer_done) begin
                        pnl_oe_n   <= 1'b1;
                        plane      <= last_plane ? '0 : plane + 1'b1;
                        row        <= row_next;
                        frame_done <= last_plane && last_row;
                        if (enable) begin
                            state       <= ST_FETCH_T;
                            mem_read    <= 1'b1;
                            mem_address <= pix_addr(32'(row_next), 32'd0);
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench for led_matrix_scanner on a 4x4 panel with two BCM planes.
module tb_led_matrix_scanner;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int CB = 2;
    localparam int BT = 2;
    localparam int FB = 'h100;
    localparam int AW = 16;
    localparam int RW = 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic [AW-1:0] mem_address;
    logic          mem_read;
    logic [31:0]   mem_readdata = 32'h0;
    logic [5:0]    pnl_rgb;
    logic [RW-1:0] pnl_row;
    logic          pnl_clk;
    logic          pnl_lat;
    logic          pnl_oe_n;
    logic          frame_done;

    logic [31:0]   ram [0:255];
    logic [RW-1:0] prev_row_g = '0;
    int            checks = 0;
    int            failures = 0;

    led_matrix_scanner #(
        .WIDTH(W), .HEIGHT(H), .COLOR_BITS(CB), .FB_BASE(FB),
        .BASE_TICKS(BT), .ADDR_W(AW), .ROW_W(RW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_readdata (mem_readdata),
        .pnl_rgb      (pnl_rgb),
        .pnl_row      (pnl_row),
        .pnl_clk      (pnl_clk),
        .pnl_lat      (pnl_lat),
        .pnl_oe_n     (pnl_oe_n),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // Latency-1 RAM; garbage when no read was issued so wrong-latency capture shows up.
    always @(posedge clk) begin
        if (mem_read) mem_readdata <= ram[mem_address[7:0]];
        else          mem_readdata <= 32'hDEAD_BEEF;
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (pnl_oe_n !== 1'b1) begin failures++; $display("FAIL reset_oe_n: got %b expected 1", pnl_oe_n); end
        checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL reset_mem_read: got %b expected 0", mem_read); end
        checks++; if (mem_address !== 16'h0) begin failures++; $display("FAIL reset_mem_address: got %h expected 0000", mem_address); end
        checks++; if (pnl_rgb !== 6'h0) begin failures++; $display("FAIL reset_rgb: got %b expected 000000", pnl_rgb); end
        checks++; if ({pnl_row, pnl_clk, pnl_lat, frame_done} !== 4'b0) begin
            failures++; $display("FAIL reset_misc: got row/clk/lat/fd=%b expected 0000", {pnl_row, pnl_clk, pnl_lat, frame_done});
        end
    endtask

    // Pushes the expected reads and shifted pixels for one row-plane, then follows
    // the DUT until the first cycle after DISPLAY, popping as events appear.
    task automatic scan_row_plane(input int row, input int plane, input bit exp_fd, input int drop_at);
        logic [AW-1:0] aq[$];
        logic [5:0]    rq[$];
        logic [AW-1:0] ea;
        logic [5:0]    er;
        logic [31:0]   t, bw;
        int            b, edges, oe_cnt, cyc, fd_seen;
        bit            latched, shown, prev_clk;
        b = 8 - CB + plane;
        edges = 0; oe_cnt = 0; cyc = 0; fd_seen = 0;
        latched = 0; shown = 0; prev_clk = 0;
        for (int c = 0; c < W; c++) begin
            aq.push_back(AW'(FB + row * W + c));
            aq.push_back(AW'(FB + (row + H / 2) * W + c));
            t  = ram[8'(FB + row * W + c)] >> b;
            bw = ram[8'(FB + (row + H / 2) * W + c)] >> b;
            rq.push_back({t[16], t[8], t[0], bw[16], bw[8], bw[0]});
        end
        forever begin
            if (shown && pnl_oe_n) begin
                checks++; if (oe_cnt != (BT << plane)) begin failures++; $display("FAIL display_len r%0d p%0d: got %0d expected %0d", row, plane, oe_cnt, BT << plane); end
                checks++; if (frame_done !== exp_fd) begin failures++; $display("FAIL frame_done r%0d p%0d: got %b expected %b", row, plane, frame_done, exp_fd); end
                checks++; if (fd_seen != 0) begin failures++; $display("FAIL stray_frame_done r%0d p%0d: got %0d pulses expected 0", row, plane, fd_seen); end
                return;
            end
            if (cyc == drop_at) enable = 1'b0;
            if (mem_read) begin
                checks++;
                if (aq.size() == 0) begin
                    failures++; $display("FAIL extra_read r%0d p%0d: got read of %h expected none", row, plane, mem_address);
                end else begin
                    ea = aq.pop_front();
                    if (mem_address !== ea) begin failures++; $display("FAIL mem_address r%0d p%0d: got %h expected %h", row, plane, mem_address, ea); end
                end
            end
            if (pnl_clk && !prev_clk) begin
                edges++;
                checks++;
                if (rq.size() == 0) begin
                    failures++; $display("FAIL extra_pnl_clk r%0d p%0d: got edge %0d expected %0d", row, plane, edges, W);
                end else begin
                    er = rq.pop_front();
                    if (pnl_rgb !== er) begin failures++; $display("FAIL pnl_rgb r%0d p%0d: got %b expected %b", row, plane, pnl_rgb, er); end
                end
            end
            if (pnl_row !== prev_row_g) begin
                checks++; if (pnl_lat !== 1'b1) begin failures++; $display("FAIL row_change_unblanked: got row %0d with lat=%b expected lat=1", pnl_row, pnl_lat); end
            end
            if (pnl_lat) begin
                latched = 1;
                checks++; if (edges != W) begin failures++; $display("FAIL clk_edges r%0d p%0d: got %0d expected %0d", row, plane, edges, W); end
                checks++; if ({pnl_oe_n, pnl_clk} !== 2'b10) begin failures++; $display("FAIL latch_oe_clk r%0d p%0d: got %b expected 10", row, plane, {pnl_oe_n, pnl_clk}); end
                checks++; if (pnl_row !== RW'(row)) begin failures++; $display("FAIL latch_row: got %0d expected %0d", pnl_row, row); end
                checks++; if (aq.size() + rq.size() != 0) begin failures++; $display("FAIL missing_items r%0d p%0d: got %0d left expected 0", row, plane, aq.size() + rq.size()); end
            end
            if (!pnl_oe_n) begin
                if (!shown) begin
                    checks++; if (!latched) begin failures++; $display("FAIL oe_before_latch r%0d p%0d: got oe_n=0 expected 1", row, plane); end
                end
                shown = 1;
                oe_cnt++;
            end
            if (frame_done && cyc > 0) fd_seen++;
            prev_clk = pnl_clk;
            prev_row_g = pnl_row;
            cyc++;
            if (cyc > 200) begin
                failures++; checks++;
                $display("FAIL timeout r%0d p%0d: got no display end in %0d cycles expected end", row, plane, cyc);
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_frame_and_wrap();
        enable = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        for (int r = 0; r < H / 2; r++)
            for (int p = 0; p < CB; p++)
                scan_row_plane(r, p, (r == H / 2 - 1) && (p == CB - 1), -1);
        scan_row_plane(0, 0, 1'b0, -1);
    endtask

    task automatic test_enable_drop();
        scan_row_plane(0, 1, 1'b0, 5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if ({mem_read, pnl_oe_n} !== 2'b01) begin failures++; $display("FAIL idle_after_drop: got read/oe_n=%b expected 01", {mem_read, pnl_oe_n}); end
        end
        enable = 1'b1;
        scan_row_plane(1, 0, 1'b0, -1);
    endtask

    task automatic test_reset_mid_display();
        int n;
        n = 0;
        while (pnl_oe_n !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n >= 100) begin failures++; $display("FAIL wait_display: got no oe_n low in %0d cycles expected low", n); end
        #1 reset_n = 1'b0;
        #1;
        checks++; if (pnl_oe_n !== 1'b1) begin failures++; $display("FAIL async_blank: got oe_n=%b expected 1", pnl_oe_n); end
        checks++; if ({mem_read, mem_address, pnl_rgb, pnl_row, pnl_clk, pnl_lat, frame_done} !== 27'h0) begin
            failures++; $display("FAIL async_reset_outputs: got %h expected 0", {mem_read, mem_address, pnl_rgb, pnl_row, pnl_clk, pnl_lat, frame_done});
        end
        @(negedge clk);
        reset_n = 1'b1;
        prev_row_g = '0;
        scan_row_plane(0, 0, 1'b0, -1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        for (int i = 0; i < W * H; i++) ram[8'(FB + i)] = $urandom & 32'h00FF_FFFF;
        ram[8'(FB)]         = 32'h00C0_4080;
        ram[8'(FB + 2 * W)] = 32'h0040_0000;
        test_reset();
        test_frame_and_wrap();
        test_enable_drop();
        test_reset_mid_display();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
- Downstream consumer of the LED-matrix frame-buffer RAM (32-bit words, single port, 16-bit word address).
- Reads pixels through a fixed-latency read master and drives a HUB75-style RGB panel: 1/(HEIGHT/2) scan, two rows per scan line, binary-code-modulation (BCM) brightness.
- Each frame-buffer word is 0x00RRGGBB; the pixel (x,y) is at word address FB_BASE + y*WIDTH + x.

Parameters:
- WIDTH, 64, panel columns (power of 2).
- HEIGHT, 32, panel rows (power of 2); scan lines = HEIGHT/2.
- COLOR_BITS, 4, BCM planes per channel, 1..8; the top COLOR_BITS bits of each 8-bit channel are used.
- FB_BASE, 0, word address of pixel (0,0).
- BASE_TICKS, 32, display clocks for plane 0; plane p displays BASE_TICKS<<p.
- ADDR_W, 16, memory word-address width.
- ROW_W, 4, row-select width = log2(HEIGHT/2).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  scanning enable, sampled at row-plane boundaries.
- mem_address  out  ADDR_W  frame-buffer word address.
- mem_read  out  1  read strobe; drives RAM chipselect; write is tied 0 externally.
- mem_readdata  in  32  RAM data, valid exactly 1 cycle after mem_read.
- pnl_rgb  out  6  {R1,G1,B1,R2,G2,B2}; 1 = LED on.
- pnl_row  out  ROW_W  row select A..D.
- pnl_clk  out  1  shift clock; data is sampled by the panel on the rising edge.
- pnl_lat  out  1  latch, active high.
- pnl_oe_n  out  1  output enable, active low.
- frame_done  out  1  one-cycle pulse after the last plane of the last row.

Behaviour:
- Reset state (asynchronous): state IDLE.
  - All outputs 0 except pnl_oe_n=1.
  - Row counter, plane counter and column counter = 0.
- FSM states: IDLE -> FETCH_T -> FETCH_B -> SHIFT_LO -> SHIFT_HI -> (next column: FETCH_T | last column: LATCH) -> DISPLAY -> (next plane/row: FETCH_T | enable=0: IDLE).
- IDLE:
  - pnl_oe_n=1.
  - Leaves to FETCH_T when enable=1.
- FETCH_T:
  - mem_read=1, mem_address = FB_BASE + row*WIDTH + col.
- FETCH_B:
  - Capture the top word.
  - mem_read=1, mem_address = FB_BASE + (row+HEIGHT/2)*WIDTH + col.
- SHIFT_LO:
  - Capture the bottom word.
  - pnl_rgb = selected bit b = 8-COLOR_BITS+plane of channels R[23:16], G[15:8], B[7:0] (top, then bottom).
  - pnl_clk=0.
- SHIFT_HI:
  - pnl_clk=1, pnl_rgb held.
- Each column therefore takes 4 cycles; exactly WIDTH rising edges of pnl_clk occur per row-plane.
- mem_read is low in every other state.
- Address arithmetic: computed in ADDR_W bits; wraps modulo 2^ADDR_W with no error.
- LATCH (1 cycle):
  - pnl_oe_n=1, pnl_lat=1, pnl_clk=0.
  - pnl_row updates to the current row in this cycle, so the row changes only while blanked.
- DISPLAY:
  - pnl_oe_n=0 for exactly BASE_TICKS<<plane cycles; pnl_lat=0.
  - On exit:
    - plane increments.
    - At COLOR_BITS-1 the plane wraps to 0 and the row increments.
    - At the last row, the row wraps to 0 and frame_done pulses in the first cycle after DISPLAY.
- Ordering: plane 0..COLOR_BITS-1 per row, rows 0..HEIGHT/2-1, then repeat continuously.
- enable:
  - Sampled only on DISPLAY exit.
  - If low, go to IDLE with pnl_oe_n=1 and counters retained; resume from the retained row/plane when enable=1.
  - enable deasserted mid-shift has no effect until the boundary.
- Reset mid-operation: immediate return to reset state; the panel is blanked (pnl_oe_n=1) asynchronously.
- No waitrequest: the RAM is fixed latency 1, and the block must not issue reads that expect a different latency.

Decomposition:
- Package led_matrix_pkg:
  - FSM state enum.
  - HUB75 pin index constants (R1..B2).
  - Helper function for plane bit index (8-COLOR_BITS+plane).
- Sub-module led_matrix_bcm_timer:
  - Loadable down-counter.
  - Load value BASE_TICKS<<plane, width ROW_W-independent: log2(BASE_TICKS)+COLOR_BITS bits.
  - Asserts done on terminal count.
  - Used by DISPLAY.

Test Plan:
- Use WIDTH=4, HEIGHT=4, COLOR_BITS=2, BASE_TICKS=2, FB_BASE=0x0100, with the RAM model at latency 1.
  - After reset_n rises with enable=1, the first mem_address values are 0x0100, 0x0108, 0x0101, 0x0109.
  - pnl_oe_n=1 until LATCH.
- Pixel (0,0)=0x00C04080 and (0,2)=0x00400000:
  - plane 0 (bit 6): first shifted pnl_rgb = 6'b110_100.
  - plane 1 (bit 7): 6'b101_000.
- Timing per row-plane:
  - exactly 4 pnl_clk rising edges, then 1 cycle of pnl_lat=1 with pnl_oe_n=1.
  - pnl_oe_n low for 2 cycles (plane 0) and 4 cycles (plane 1).
  - pnl_row steps 0 -> 1 only in a LATCH cycle.
- frame_done:
  - pulses once after row 1 / plane 1 DISPLAY.
  - the next mem_address is 0x0100 again (row wrap).
- enable dropped during shifting:
  - the current row-plane completes, including DISPLAY, then IDLE with pnl_oe_n=1.
  - on re-enable, the scan resumes at the next plane/row, not row 0.
- reset_n asserted during DISPLAY:
  - pnl_oe_n=1 and all other outputs 0 in the same cycle without a clock edge.
  - after release, the scan restarts at address 0x0100.
